// File: rtl/led_sequencer.sv
// led_sequencer: autonomous pattern player for the 5-bit LED register peripheral.
// Avalon-MM slave side holds up to eight patterns, a step period and control bits.
// Avalon-MM master side writes each pattern in turn into the LED data register.
module led_sequencer #(
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned LED_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    // Avalon-MM slave (Nios side)
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic        AVL_CS,
    input  logic [3:0]  AVL_BYTE_EN,
    input  logic [3:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    // Avalon-MM master (LED peripheral side)
    output logic        M_CS,
    output logic        M_WRITE,
    output logic [1:0]  M_ADDR,
    output logic [3:0]  M_BYTE_EN,
    output logic [31:0] M_WRITEDATA,
    input  logic        M_WAITREQUEST
);

    // Register map (word addresses); 8..15 are the pattern slots
    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PERIOD = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;

    // Sequencer states
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    // Software-visible registers
    logic                r_run;
    logic                r_loop;
    logic [2:0]          r_last;
    logic                r_done;
    logic [PERIOD_W-1:0] r_period;
    logic [LED_W-1:0]    r_pat [0:7];

    // Sequencer state
    logic [1:0]          r_state;
    logic [2:0]          r_idx;
    logic [PERIOD_W-1:0] r_cnt;

    // Next-state values
    logic [1:0]          w_state_nxt;
    logic [2:0]          w_idx_nxt;
    logic [PERIOD_W-1:0] w_cnt_nxt;
    logic                w_finish;

    // Slave-side decode
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_period_wr;
    logic        w_pat_wr;
    logic        w_run_field_wr;
    logic        w_start;
    logic        w_stop;
    logic        w_busy;
    logic        w_at_last;
    logic        w_writing;
    logic [31:0] w_be_mask;
    logic [31:0] w_period_ext;
    logic [31:0] w_period_merge;
    logic [31:0] w_pat_ext;
    logic [31:0] w_pat_merge;
    logic [31:0] w_out_ext;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr        = AVL_CS & AVL_WRITE;
    assign w_ctrl_wr   = w_wr && (AVL_ADDR == ADDR_CTRL);
    assign w_period_wr = w_wr && (AVL_ADDR == ADDR_PERIOD);
    assign w_pat_wr    = w_wr && AVL_ADDR[3];

    // All CTRL fields live in byte 0, so only BYTE_EN[0] lets RUN/LOOP/LAST change
    assign w_run_field_wr = w_ctrl_wr && AVL_BYTE_EN[0];
    assign w_start        = w_run_field_wr && AVL_WRITEDATA[0];
    // Stop request: RUN being written to 0 now, or already cleared by an earlier abort
    assign w_stop         = w_run_field_wr ? !AVL_WRITEDATA[0] : !r_run;

    assign w_busy    = (r_state != StIdle);
    // LAST may have been lowered below idx mid-run; treat that as being at LAST
    assign w_at_last = (r_idx >= r_last);
    assign w_writing = (r_state == StWrite);

    assign w_be_mask = {{8{AVL_BYTE_EN[3]}}, {8{AVL_BYTE_EN[2]}},
                        {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};

    // Zero-extend the narrow registers to bus width for readback and byte merging
    always_comb begin
        w_period_ext                 = '0;
        w_period_ext[PERIOD_W-1:0]   = r_period;
        w_pat_ext                    = '0;
        w_pat_ext[LED_W-1:0]         = r_pat[AVL_ADDR[2:0]];
        w_out_ext                    = '0;
        w_out_ext[LED_W-1:0]         = r_pat[r_idx];
    end

    assign w_period_merge = (w_period_ext & ~w_be_mask) | (AVL_WRITEDATA & w_be_mask);
    assign w_pat_merge    = (w_pat_ext & ~w_be_mask) | (AVL_WRITEDATA & w_be_mask);

    // Bits above the register widths are intentionally dropped
    assign w_unused = ^{w_period_merge, w_pat_merge};

    // Sequencer next-state: start, master write handshake, step timer and wrap/finish
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_finish    = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = StWrite;
                end
            end
            StWrite: begin
                // An Avalon write in flight must be held until accepted, even on abort
                if (!M_WAITREQUEST) begin
                    if (w_stop) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_cnt_nxt   = r_period;
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                if (w_stop) begin
                    w_state_nxt = StIdle;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - PERIOD_W'(1);
                end else if (!w_at_last) begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_state_nxt = StWrite;
                end else if (r_loop) begin
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = StWrite;
                end else begin
                    w_finish    = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // CTRL and DONE: software writes, cleared RUN / set DONE on natural completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run  <= 1'b0;
            r_loop <= 1'b0;
            r_last <= 3'd0;
            r_done <= 1'b0;
        end else begin
            if (w_run_field_wr) begin
                r_run  <= AVL_WRITEDATA[0];
                r_loop <= AVL_WRITEDATA[1];
                r_last <= AVL_WRITEDATA[6:4];
            end
            // Completion wins over a coincident CTRL write
            if (w_finish) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end else if (w_ctrl_wr) begin
                r_done <= 1'b0;
            end
        end
    end

    // PERIOD register, byte-enable merged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period <= '0;
        end else if (w_period_wr) begin
            r_period <= w_period_merge[PERIOD_W-1:0];
        end
    end

    // Pattern slots, byte-enable merged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_pat[i] <= '0;
            end
        end else if (w_pat_wr) begin
            r_pat[AVL_ADDR[2:0]] <= w_pat_merge[LED_W-1:0];
        end
    end

    // Zero-latency readback, forced to 0 outside a selected read
    always_comb begin
        w_rdata = '0;
        if (AVL_CS && AVL_READ) begin
            if (AVL_ADDR[3]) begin
                w_rdata = w_pat_ext;
            end else begin
                case (AVL_ADDR)
                    ADDR_CTRL: begin
                        w_rdata[0]   = r_run;
                        w_rdata[1]   = r_loop;
                        w_rdata[6:4] = r_last;
                    end
                    ADDR_PERIOD: begin
                        w_rdata = w_period_ext;
                    end
                    ADDR_STATUS: begin
                        w_rdata[0]   = w_busy;
                        w_rdata[1]   = r_done;
                        w_rdata[6:4] = r_idx;
                    end
                    default: begin
                        w_rdata = '0;
                    end
                endcase
            end
        end
    end

    assign AVL_READDATA = w_rdata;

    // Master outputs decode straight from state so reset drops M_WRITE asynchronously
    assign M_CS        = w_writing;
    assign M_WRITE     = w_writing;
    assign M_ADDR      = 2'b00;
    assign M_BYTE_EN   = 4'b0001;
    assign M_WRITEDATA = w_writing ? w_out_ext : 32'd0;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: register-map vector table plus scoreboarded master-write sequences.
module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        AVL_READ, AVL_WRITE, AVL_CS;
    logic [3:0]  AVL_BYTE_EN, AVL_ADDR;
    logic [31:0] AVL_WRITEDATA, AVL_READDATA;
    logic        M_CS, M_WRITE;
    logic [1:0]  M_ADDR;
    logic [3:0]  M_BYTE_EN;
    logic [31:0] M_WRITEDATA;
    logic        M_WAITREQUEST;

    led_sequencer #(.PERIOD_W(24), .LED_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_CS        (AVL_CS),
        .AVL_BYTE_EN   (AVL_BYTE_EN),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .M_CS          (M_CS),
        .M_WRITE       (M_WRITE),
        .M_ADDR        (M_ADDR),
        .M_BYTE_EN     (M_BYTE_EN),
        .M_WRITEDATA   (M_WRITEDATA),
        .M_WAITREQUEST (M_WAITREQUEST)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rexp;
    } vec_t;

    vec_t        vecs [14];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          wr_cyc;
    int          c0;
    int          done_cyc;
    logic        busy_ok;
    logic [31:0] rd;
    logic [31:0] mon_exp;
    logic [31:0] exp_q [$];
    int          acc_t [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Scoreboard: every accepted master write pops the next expected pattern
    always @(negedge clk) begin
        if (reset && M_CS && M_WRITE && !M_WAITREQUEST) begin
            acc_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL m_unexpected_write: got data %h, required no write (cycle %0d)",
                         M_WRITEDATA, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("m_writedata", M_WRITEDATA, mon_exp);
            end
            chk("m_addr", 32'(M_ADDR), 32'd0);
            chk("m_byte_en", 32'(M_BYTE_EN), 32'd1);
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        #1;
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
        AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        @(posedge clk);
        #1;
        wr_cyc = cyc;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'b0000;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        #1;
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = a;
        @(negedge clk);
        d = AVL_READDATA;
        @(posedge clk);
        #1;
        AVL_CS = 1'b0; AVL_READ = 1'b0;
    endtask

    // Hold a STATUS read and record the first cycle DONE shows
    task automatic wait_done(output int dc, output logic bok);
        dc  = -1;
        bok = 1'b1;
        #1;
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = 4'd2;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (AVL_READDATA[1]) begin
                dc = cyc;
                break;
            end
            bok = bok & AVL_READDATA[0];
        end
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
        AVL_BYTE_EN = 4'b0000; AVL_ADDR = 4'd0; AVL_WRITEDATA = 32'd0;
        M_WAITREQUEST = 1'b0;

        vecs[0]  = '{4'd1,  32'hFFFF_FFFF, 4'b0010, 32'h0000_FF00};
        vecs[1]  = '{4'd1,  32'hFFFF_FFFF, 4'b1111, 32'h00FF_FFFF};
        vecs[2]  = '{4'd1,  32'h1234_5678, 4'b0101, 32'h0034_FF78};
        vecs[3]  = '{4'd8,  32'hFFFF_FFFF, 4'b1111, 32'h0000_001F};
        vecs[4]  = '{4'd8,  32'h0000_0300, 4'b0010, 32'h0000_001F};
        vecs[5]  = '{4'd15, 32'h0000_0015, 4'b0001, 32'h0000_0015};
        vecs[6]  = '{4'd11, 32'h0000_00EA, 4'b0001, 32'h0000_000A};
        vecs[7]  = '{4'd3,  32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
        vecs[8]  = '{4'd2,  32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
        vecs[9]  = '{4'd0,  32'h0000_007E, 4'b0001, 32'h0000_0072};
        vecs[10] = '{4'd0,  32'h0000_FFFF, 4'b1110, 32'h0000_0072};
        vecs[11] = '{4'd0,  32'h0000_0000, 4'b1111, 32'h0000_0000};
        vecs[12] = '{4'd7,  32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
        vecs[13] = '{4'd1,  32'h0000_0000, 4'b1111, 32'h0000_0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_write", 32'(M_WRITE), 32'd0);
        chk("rst_m_cs", 32'(M_CS), 32'd0);
        chk("rst_m_writedata", M_WRITEDATA, 32'd0);
        chk("rst_m_addr", 32'(M_ADDR), 32'd0);
        chk("rst_m_byte_en", 32'(M_BYTE_EN), 32'd1);
        chk("rst_readdata", AVL_READDATA, 32'd0);
        reset = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            chk($sformatf("rst_reg%0d", a), rd, 32'd0);
        end

        // Register map and byte enables
        for (int i = 0; i < 14; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            bus_read(vecs[i].addr, rd);
            chk($sformatf("map_vec%0d", i), rd, vecs[i].rexp);
        end

        // One-shot: 1, 2, 4 spaced PERIOD+2 = 5 cycles apart
        bus_write(4'd8, 32'h01, 4'hF);
        bus_write(4'd9, 32'h02, 4'hF);
        bus_write(4'd10, 32'h04, 4'hF);
        bus_write(4'd1, 32'h03, 4'hF);
        acc_t.delete();
        exp_q.push_back(32'h01); exp_q.push_back(32'h02); exp_q.push_back(32'h04);
        bus_write(4'd0, 32'h21, 4'b0001);
        c0 = wr_cyc;
        wait_done(done_cyc, busy_ok);
        chk("os_busy_during_run", 32'(busy_ok), 32'd1);
        chk("os_done_cycle", done_cyc, c0 + 15);
        chk("os_n_writes", acc_t.size(), 3);
        if (acc_t.size() == 3) begin
            chk("os_start_latency", acc_t[0], c0);
            chk("os_gap1", acc_t[1] - acc_t[0], 5);
            chk("os_gap2", acc_t[2] - acc_t[1], 5);
        end
        bus_read(4'd2, rd);
        chk("os_status", rd & 32'h3, 32'h2);
        bus_read(4'd0, rd);
        chk("os_ctrl", rd, 32'h20);
        // Readback gating: no READ means zero
        #1;
        AVL_ADDR = 4'd1; AVL_CS = 1'b1; AVL_READ = 1'b0;
        @(negedge clk);
        chk("rdata_no_read", AVL_READDATA, 32'd0);
        AVL_READ = 1'b1;
        #1;
        chk("rdata_period", AVL_READDATA, 32'd3);
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        @(posedge clk);

        // Loop with PERIOD=0, then abort during WAIT
        bus_write(4'd8, 32'h0A, 4'hF);
        bus_write(4'd9, 32'h15, 4'hF);
        bus_write(4'd1, 32'h00, 4'hF);
        acc_t.delete();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h0A);
            exp_q.push_back(32'h15);
        end
        bus_write(4'd0, 32'h13, 4'b0001);
        c0 = wr_cyc;
        busy_ok = 1'b1;
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 4'd2;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            if (acc_t.size() >= 6) break;
            #3;
            busy_ok = busy_ok & AVL_READDATA[0];
        end
        bus_write(4'd0, 32'h12, 4'b0001);
        bus_read(4'd2, rd);
        chk("loop_abort_status", rd & 32'h3, 32'h0);
        chk("loop_busy", 32'(busy_ok), 32'd1);
        repeat (5) @(posedge clk);
        chk("loop_n_writes", acc_t.size(), 6);
        chk("loop_q_empty", exp_q.size(), 0);
        if (acc_t.size() == 6) begin
            chk("loop_start_latency", acc_t[0], c0);
            for (int k = 1; k < 6; k++) begin
                chk($sformatf("loop_gap%0d", k), acc_t[k] - acc_t[k-1], 2);
            end
        end

        // Waitrequest held 4 cycles on the second write
        bus_write(4'd8, 32'h03, 4'hF);
        bus_write(4'd9, 32'h05, 4'hF);
        bus_write(4'd10, 32'h06, 4'hF);
        bus_write(4'd1, 32'h02, 4'hF);
        acc_t.delete();
        exp_q.push_back(32'h03); exp_q.push_back(32'h05); exp_q.push_back(32'h06);
        bus_write(4'd0, 32'h21, 4'b0001);
        c0 = wr_cyc;
        repeat (4) @(posedge clk);
        #1;
        M_WAITREQUEST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("wr_stall_write%0d", k), 32'(M_WRITE), 32'd1);
            chk($sformatf("wr_stall_data%0d", k), M_WRITEDATA, 32'h05);
            @(posedge clk);
        end
        #1;
        M_WAITREQUEST = 1'b0;
        wait_done(done_cyc, busy_ok);
        chk("wr_done_cycle", done_cyc, c0 + 16);
        chk("wr_n_writes", acc_t.size(), 3);
        if (acc_t.size() == 3) begin
            chk("wr_gap1", acc_t[1] - acc_t[0], 8);
            chk("wr_gap2", acc_t[2] - acc_t[1], 4);
        end

        // Abort while the second write is stalled
        bus_write(4'd8, 32'h11, 4'hF);
        bus_write(4'd9, 32'h12, 4'hF);
        bus_write(4'd1, 32'h01, 4'hF);
        acc_t.delete();
        exp_q.push_back(32'h11); exp_q.push_back(32'h12);
        bus_write(4'd0, 32'h13, 4'b0001);
        c0 = wr_cyc;
        repeat (3) @(posedge clk);
        #1;
        M_WAITREQUEST = 1'b1;
        bus_write(4'd0, 32'h12, 4'b0001);
        @(negedge clk);
        chk("sa_hold_write", 32'(M_WRITE), 32'd1);
        chk("sa_hold_data", M_WRITEDATA, 32'h12);
        @(posedge clk);
        #1;
        M_WAITREQUEST = 1'b0;
        @(posedge clk);
        bus_read(4'd2, rd);
        chk("sa_status", rd & 32'h3, 32'h0);
        chk("sa_m_write_idle", 32'(M_WRITE), 32'd0);
        repeat (5) @(posedge clk);
        chk("sa_n_writes", acc_t.size(), 2);
        chk("sa_q_empty", exp_q.size(), 0);
        if (acc_t.size() == 2) begin
            chk("sa_accept_cycle", acc_t[1], c0 + 5);
        end

        // Reset asserted mid-transfer
        bus_write(4'd0, 32'h13, 4'b0001);
        #1;
        chk("mr_pre_write", 32'(M_WRITE), 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_write_async", 32'(M_WRITE), 32'd0);
        chk("mr_cs_async", 32'(M_CS), 32'd0);
        chk("mr_data_async", M_WRITEDATA, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            chk($sformatf("mr_reg%0d", a), rd, 32'd0);
        end
        repeat (4) @(posedge clk);
        chk("mr_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Autonomous pattern player for the 5-bit LED register peripheral. Software loads up to eight 5-bit patterns and a step period through an Avalon-MM slave, then sets RUN. The block then acts as an Avalon-MM master and writes each pattern in turn into the LED peripheral's data register, either once or looping. It sits between the Nios bus (slave side) and the LED peripheral's slave port (master side) in the Platform Designer system.

## Interface

Parameters:
- PERIOD_W, 24: width of the step-period register and down-counter.
- LED_W, 5: pattern width; must not exceed 32.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- AVL_READ  in  1  slave read.
- AVL_WRITE  in  1  slave write.
- AVL_CS  in  1  slave chip select.
- AVL_BYTE_EN  in  4  slave byte enables; honoured per byte on all RW registers.
- AVL_ADDR  in  4  slave word address.
- AVL_WRITEDATA  in  32  slave write data.
- AVL_READDATA  out  32  slave read data; zero-latency (combinational from AVL_ADDR).
- M_CS  out  1  master chip select to LED peripheral.
- M_WRITE  out  1  master write.
- M_ADDR  out  2  master address; constant 0.
- M_BYTE_EN  out  4  constant 4'b0001.
- M_WRITEDATA  out  32  {zero-extend, pattern}.
- M_WAITREQUEST  in  1  slave stall; tie to 0 for the LED peripheral.

## Operation

Register map (word addresses):
- 0, CTRL, RW: bit0 RUN, bit1 LOOP, bits[6:4] LAST (index of the final pattern; sequence length is LAST+1).
- 1, PERIOD, RW: bits[PERIOD_W-1:0].
- 2, STATUS, RO: bit0 BUSY, bit1 DONE (sticky), bits[6:4] current index.
- 8..15, PAT0..PAT7, RW: bits[LED_W-1:0].
- All other addresses read 0 and ignore writes.
- Unused register bits read 0.

State machine: IDLE, WRITE, WAIT.
- IDLE:
  - A slave write to CTRL with RUN=1 clears DONE, sets idx=0 and goes to WRITE.
  - Any write to CTRL clears DONE.
- WRITE:
  - M_CS=M_WRITE=1; M_WRITEDATA = PAT[idx], sampled live.
  - Holds while M_WAITREQUEST=1.
  - On the first edge with M_WAITREQUEST=0, the write is accepted: load cnt=PERIOD and go to WAIT.
- WAIT:
  - If cnt≠0, cnt decrements.
  - If cnt=0 and idx≠LAST: idx+1, go to WRITE.
  - If cnt=0 and idx=LAST and LOOP=1: idx=0, go to WRITE.
  - If cnt=0 and idx=LAST and LOOP=0: clear RUN, set DONE, go to IDLE.
- Abort (slave write with RUN=0 while BUSY):
  - In WAIT: go to IDLE immediately; DONE is not set.
  - In WRITE: the outstanding transfer is held until accepted (Avalon rule), then the block goes to IDLE.
- Rewriting CTRL with RUN=1 while busy:
  - Updates LOOP and LAST only; it does not restart.
  - If the new LAST < idx, the sequence ends (or wraps) at the next WAIT expiry, treated as idx=LAST.
- PERIOD and PAT writes during a run take effect at the next cnt load or next WRITE respectively.
- BUSY = (state ≠ IDLE).

## Timing

- Reset values:
  - All registers 0; state IDLE; idx=0; cnt=0.
  - M_CS=M_WRITE=0; M_WRITEDATA=0; AVL_READDATA=0.
  - M_ADDR=0; M_BYTE_EN=4'b0001 (constant).
- Start latency: CTRL write at edge T puts M_WRITE high in cycle T+1.
- With zero waitrequest, consecutive master writes are exactly PERIOD+2 cycles apart: 1 WRITE cycle plus PERIOD+1 WAIT cycles. PERIOD=0 gives a write every 2 cycles.
- Each waitrequest cycle extends the step by one.
- DONE and RUN=0 become visible the cycle after the final WAIT expiry.
- AVL_READDATA is valid in the same cycle as AVL_CS&AVL_READ; it is 0 otherwise.
- Asserting reset mid-transfer forces M_WRITE low asynchronously and clears all state.

## Test plan

- Reset: assert reset low mid-run -> M_WRITE=0 immediately; all registers read 0 after release.
- One-shot:
  - Setup: PAT0..2 = 5'h01, 5'h02, 5'h04; PERIOD=3; CTRL = RUN, LAST=2.
  - Expect: three master writes of 1, 2, 4, spaced 5 cycles apart; then STATUS=2'b10 (DONE, not BUSY) and CTRL.RUN=0.
- Loop:
  - Setup: LAST=1, LOOP=1, PERIOD=0.
  - Expect: write data alternates PAT0, PAT1, PAT0… every 2 cycles; BUSY stays 1.
- Waitrequest: hold M_WAITREQUEST=1 for 4 cycles on the second write -> M_WRITE and M_WRITEDATA remain stable; that step lengthens by 4 cycles.
- Abort:
  - Write RUN=0 during WAIT -> IDLE the next cycle, DONE=0.
  - Write RUN=0 during a stalled WRITE -> the write completes when waitrequest drops, then IDLE.
- Byte enables and map:
  - Write PERIOD=32'hFFFFFFFF with BYTE_EN=4'b0010 -> reads back 32'h0000FF00.
  - Read address 3 -> 0.
